// File: rtl/pipeline_types.sv
// Shared pipeline types: bus word and the uncached data-port FSM states.
package pipeline_types;

  typedef logic [31:0] bus32_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } uncache_state_t;

endpackage

// File: rtl/mem_dcache.sv
// Execute-stage to data-port request channel.
interface mem_dcache;
  import pipeline_types::*;

  logic       valid;
  logic       uncache_en;
  logic       op;
  bus32_t     virtual_addr;
  bus32_t     wdata;
  logic [3:0] wstrb;
  logic       tlb_excp_cancel_req;
  logic       addr_ok;
  logic       data_ok;
  bus32_t     rdata;

  modport master (
    output valid, uncache_en, op, virtual_addr,
    output wdata, wstrb, tlb_excp_cancel_req,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  valid, uncache_en, op, virtual_addr,
    input  wdata, wstrb, tlb_excp_cancel_req,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/dcache_uncache_port.sv
// Uncached data port: one outstanding single-word load/store on the data bus.
module dcache_uncache_port
  import pipeline_types::*;
(
  input  logic             clk,
  input  logic             rst,
  mem_dcache.slave         dcache_slave,
  input  logic             flush,
  output logic             rd_req,
  output bus32_t           rd_addr,
  input  logic             rd_rdy,
  input  logic             ret_valid,
  input  bus32_t           ret_data,
  output logic             wr_req,
  output bus32_t           wr_addr,
  output bus32_t           wr_data,
  output logic [3:0]       wr_strb,
  input  logic             wr_rdy,
  input  logic             wr_done
);

  uncache_state_t state_q, state_d;
  bus32_t         addr_q, addr_d;
  bus32_t         wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  bus32_t         rdata_q, rdata_d;
  logic           cancel_q, cancel_d;
  logic           req;
  logic           accept;

  assign req = (dcache_slave.valid | dcache_slave.uncache_en)
             & ~dcache_slave.tlb_excp_cancel_req;
  assign accept = (state_q == IDLE) & req & ~flush;

  assign dcache_slave.addr_ok = accept;
  assign dcache_slave.data_ok = (state_q == RESP) & ~cancel_q;
  assign dcache_slave.rdata   = rdata_q;

  assign rd_req  = (state_q == RD_REQ);
  assign rd_addr = {addr_q[31:2], 2'b00};
  assign wr_req  = (state_q == WR_REQ);
  assign wr_addr = addr_q;
  assign wr_data = wdata_q;
  assign wr_strb = wstrb_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    cancel_d = cancel_q;
    if (state_q != IDLE && flush) cancel_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = dcache_slave.virtual_addr;
          wdata_d  = dcache_slave.wdata;
          wstrb_d  = dcache_slave.wstrb;
          cancel_d = 1'b0;
          state_d  = dcache_slave.op ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ:  if (rd_rdy) state_d = RD_WAIT;
      RD_WAIT: begin
        if (ret_valid) begin
          rdata_d = ret_data;
          state_d = RESP;
        end
      end
      WR_REQ:  if (wr_rdy) state_d = WR_RESP;
      WR_RESP: if (wr_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

endmodule
